// File: rtl/palette_lut_fader.sv
// Palette lookup with run-time writable palette RAM, transparency flag and
// frame-synchronous global brightness fade. Two-cycle index-to-colour latency.
module palette_lut_fader #(
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned COLOR_W         = 4,
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [IDX_W-1:0]       index,
  input  logic                   pix_valid,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic                   frame_start,
  input  logic [1:0]             fade_cmd,
  input  logic [7:0]             fade_frames,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  output logic                   out_valid,
  output logic                   fade_busy,
  output logic [LEVEL_W:0]       fade_level
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned ENT_W  = 3 * COLOR_W;
  localparam int unsigned PROD_W = COLOR_W + LEVEL_W + 1;
  localparam logic [LEVEL_W:0] MAXL     = (LEVEL_W+1)'(1 << LEVEL_W);
  localparam logic [LEVEL_W:0] LVL_ONE  = (LEVEL_W+1)'(1);
  localparam logic [IDX_W-1:0] TRANS_IX = IDX_W'(TRANSPARENT_IDX);

  typedef enum logic [1:0] {IDLE = 2'd0, FADE_IN = 2'd1, FADE_OUT = 2'd2} state_t;

  logic [ENT_W-1:0] palette [DEPTH];

  logic [ENT_W-1:0] s1_data;
  logic             s1_valid;
  logic             s1_trans;

  state_t           state, state_n;
  logic [LEVEL_W:0] level, level_n;
  logic [7:0]       cnt, cnt_n;
  logic [7:0]       frames_m1;

  // MAXL is a power of two, so the divide reduces to dropping LEVEL_W bits.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LEVEL_W:0]   l);
    return COLOR_W'((PROD_W'(c) * PROD_W'(l)) / PROD_W'(MAXL));
  endfunction

  // Palette storage: cleared on reset, written on any cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) palette[i] <= '0;
    end else if (wr_en) begin
      palette[wr_addr] <= wr_data;
    end
  end

  // Stage 1: palette read (old contents on a same-address write), valid and transparency
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_trans <= 1'b0;
    end else begin
      s1_data  <= palette[index];
      s1_valid <= pix_valid;
      s1_trans <= (index == TRANS_IX);
    end
  end

  // Stage 2: brightness-scaled colour, gated by valid
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid   <= s1_valid;
      transparent <= s1_valid & s1_trans;
      if (s1_valid) begin
        red   <= scale(s1_data[ENT_W-1 -: COLOR_W], level);
        green <= scale(s1_data[2*COLOR_W-1 -: COLOR_W], level);
        blue  <= scale(s1_data[COLOR_W-1:0], level);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  assign frames_m1 = (fade_frames == 8'd0) ? 8'd0 : fade_frames - 8'd1;

  // Fade FSM state, level and frame counter registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      level <= MAXL;
      cnt   <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      cnt   <= cnt_n;
    end
  end

  // Fade next-state: an acting command pre-empts frame counting for that cycle
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    if (fade_cmd == 2'b11) begin
      state_n = IDLE;
      level_n = MAXL;
      cnt_n   = '0;
    end else if (fade_cmd == 2'b01 && state != FADE_IN) begin
      state_n = FADE_IN;
      cnt_n   = '0;
    end else if (fade_cmd == 2'b10 && state != FADE_OUT) begin
      state_n = FADE_OUT;
      cnt_n   = '0;
    end else begin
      case (state)
        FADE_IN: begin
          if (level == MAXL) begin
            state_n = IDLE;
          end else if (frame_start) begin
            if (cnt >= frames_m1) begin
              cnt_n   = '0;
              level_n = level + LVL_ONE;
              if (level == MAXL - LVL_ONE) state_n = IDLE;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        end
        FADE_OUT: begin
          if (level == '0) begin
            state_n = IDLE;
          end else if (frame_start) begin
            if (cnt >= frames_m1) begin
              cnt_n   = '0;
              level_n = level - LVL_ONE;
              if (level == LVL_ONE) state_n = IDLE;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fade_busy  = (state != IDLE);
  assign fade_level = level;

endmodule

// File: tb/tb_palette_lut_fader.sv
// Randomised and directed bench for palette_lut_fader against a cycle-level
// behavioural model of palette contents, pipeline and fade level.
module tb_palette_lut_fader;

  logic        Clk;
  logic        Reset_n;
  logic [3:0]  index;
  logic        pix_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_start;
  logic [1:0]  fade_cmd;
  logic [7:0]  fade_frames;
  logic [3:0]  red, green, blue;
  logic        transparent, out_valid, fade_busy;
  logic [4:0]  fade_level;

  palette_lut_fader #(
    .IDX_W(4), .COLOR_W(4), .LEVEL_W(4), .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .index(index), .pix_valid(pix_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .fade_cmd(fade_cmd), .fade_frames(fade_frames),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .out_valid(out_valid), .fade_busy(fade_busy), .fade_level(fade_level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: palette, stage-1 contents, expected outputs, fade
  int pal_m [16];
  int s1c, s1v, s1t;
  int m_r, m_g, m_b, m_t, m_v;
  int lvl, dir, frames_seen;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_step();
    int steps_per;
    bit acted;
    if (!Reset_n) begin
      foreach (pal_m[i]) pal_m[i] = 0;
      s1c = 0; s1v = 0; s1t = 0;
      m_r = 0; m_g = 0; m_b = 0; m_t = 0; m_v = 0;
      lvl = 16; dir = 0; frames_seen = 0;
    end else begin
      m_v = s1v;
      m_t = s1v & s1t;
      m_r = s1v ? (((s1c >> 8) & 15) * lvl) / 16 : 0;
      m_g = s1v ? (((s1c >> 4) & 15) * lvl) / 16 : 0;
      m_b = s1v ? ((s1c & 15) * lvl) / 16 : 0;
      s1c = pal_m[index];
      s1v = pix_valid;
      s1t = (index == 0);
      if (wr_en) pal_m[wr_addr] = wr_data;
      acted = 1'b1;
      if (fade_cmd == 2'b11) begin
        dir = 0; lvl = 16; frames_seen = 0;
      end else if (fade_cmd == 2'b01 && dir != 1) begin
        dir = 1; frames_seen = 0;
      end else if (fade_cmd == 2'b10 && dir != -1) begin
        dir = -1; frames_seen = 0;
      end else begin
        acted = 1'b0;
      end
      if (!acted && dir != 0) begin
        steps_per = (fade_frames == 0) ? 1 : int'(fade_frames);
        if ((dir == 1 && lvl == 16) || (dir == -1 && lvl == 0)) begin
          dir = 0;
        end else if (frame_start) begin
          frames_seen++;
          if (frames_seen >= steps_per) begin
            frames_seen = 0;
            lvl += dir;
            if (lvl == 16 || lvl == 0) dir = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check("red", red, m_r);
    check("green", green, m_g);
    check("blue", blue, m_b);
    check("transparent", transparent, m_t);
    check("out_valid", out_valid, m_v);
    check("fade_busy", fade_busy, (dir != 0));
    check("fade_level", fade_level, lvl);
  endtask

  task automatic quiet();
    wr_en = 0; frame_start = 0; fade_cmd = 2'b00;
  endtask

  task automatic pulse_frame();
    frame_start = 1; tick();
    frame_start = 0; tick();
  endtask

  initial begin
    Reset_n = 0; index = 0; pix_valid = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    frame_start = 0; fade_cmd = 0; fade_frames = 1;
    tick(); tick();
    check("rst_level", fade_level, 16);
    check("rst_busy", fade_busy, 0);
    Reset_n = 1;

    // index 5 after reset reads black, index 0 flags transparent
    index = 5; pix_valid = 1; tick();
    index = 0; tick();
    check("idx5_rgb", {red, green, blue}, 12'h000);
    check("idx5_valid", out_valid, 1);
    check("idx5_trans", transparent, 0);
    pix_valid = 0; tick();
    check("idx0_trans", transparent, 1);
    tick();

    // write then read; same-cycle write/read returns old entry
    wr_en = 1; wr_addr = 3; wr_data = 12'hF84; tick();
    wr_en = 0; index = 3; pix_valid = 1; tick();
    pix_valid = 0; tick();
    check("rd_f84", {red, green, blue}, 12'hF84);
    wr_en = 1; wr_data = 12'h123; pix_valid = 1; tick();
    wr_en = 0; tick();
    check("rbw_old", {red, green, blue}, 12'hF84);
    pix_valid = 0; tick();
    check("rbw_new", {red, green, blue}, 12'h123);
    wr_en = 1; wr_data = 12'hF84; tick();
    wr_en = 0;

    // full fade-out with two frames per level step
    index = 3; pix_valid = 1; fade_frames = 2;
    fade_cmd = 2'b10; tick(); fade_cmd = 2'b00;
    for (int i = 0; i < 32; i++) begin
      pulse_frame();
      if (lvl == 8 && frames_seen == 0 && i == 15) check("lvl8_rgb", {red, green, blue}, 12'h742);
    end
    check("fo_level0", fade_level, 0);
    check("fo_busy0", fade_busy, 0);

    // reversal mid fade-out, then snap during fade-out
    fade_frames = 1; fade_cmd = 2'b11; tick();
    fade_cmd = 2'b10; tick(); fade_cmd = 2'b00;
    for (int i = 0; i < 20 && lvl != 10; i++) pulse_frame();
    check("rev_at10", fade_level, 10);
    fade_cmd = 2'b01; tick(); fade_cmd = 2'b00;
    check("rev_busy", fade_busy, 1);
    for (int i = 0; i < 20 && lvl != 16; i++) pulse_frame();
    check("rev_top", fade_level, 16);
    check("rev_idle", fade_busy, 0);
    fade_cmd = 2'b10; tick(); fade_cmd = 2'b00;
    for (int i = 0; i < 20 && lvl != 4; i++) pulse_frame();
    fade_cmd = 2'b11; tick(); fade_cmd = 2'b00;
    check("snap_level", fade_level, 16);
    check("snap_idle", fade_busy, 0);

    // fade_frames=0 steps every frame; coincident command suppresses the pulse
    fade_frames = 0; fade_cmd = 2'b10; tick(); fade_cmd = 2'b00;
    for (int i = 0; i < 3; i++) pulse_frame();
    check("ff0_level", fade_level, 13);
    fade_cmd = 2'b01; frame_start = 1; tick(); quiet();
    check("coinc_level", fade_level, 13);
    pulse_frame();
    check("coinc_next", fade_level, 14);

    // reset mid-fade at level 6 with a populated palette
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 12'($urandom_range(1, 4095)); tick();
    end
    wr_en = 0;
    fade_cmd = 2'b10; tick(); fade_cmd = 2'b00;
    for (int i = 0; i < 20 && lvl != 6; i++) pulse_frame();
    Reset_n = 0; tick(); Reset_n = 1;
    check("mid_rst_level", fade_level, 16);
    check("mid_rst_busy", fade_busy, 0);
    check("mid_rst_rgb", {red, green, blue}, 12'h000);
    for (int i = 0; i < 18; i++) begin
      index = 4'(i % 16); pix_valid = 1; tick();
      check("clr_entry", {red, green, blue}, 12'h000);
    end

    // randomised traffic
    for (int c = 0; c < 4000; c++) begin
      Reset_n     = ($urandom_range(0, 599) != 0);
      index       = 4'($urandom);
      pix_valid   = 1'($urandom);
      wr_en       = ($urandom_range(0, 5) == 0);
      wr_addr     = ($urandom_range(0, 1) == 0) ? index : 4'($urandom);
      wr_data     = 12'($urandom);
      frame_start = ($urandom_range(0, 2) == 0);
      fade_cmd    = ($urandom_range(0, 24) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 99) == 0) fade_frames = 8'($urandom_range(0, 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_lut_fader.md
Name: palette_lut_fader

Overview:
- Parametrised, writable successor to the fixed sprite/text colour palettes.
- Maps a per-pixel palette index to RGB through a run-time-loadable palette RAM.
- Flags the transparent index and applies a frame-synchronous global brightness fade (fade-in / fade-out) for title-screen and game-over transitions.
- Sits between a sprite ROM index output and the VGA colour mux.

Parameters:
- IDX_W, 4, palette index width; palette depth = 2^IDX_W entries.
- COLOR_W, 4, bits per colour channel; entry width = 3*COLOR_W, packed {R,G,B}.
- LEVEL_W, 4, fade resolution; level range 0..2^LEVEL_W (MAXL).
- TRANSPARENT_IDX, 0, index reported as transparent.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous, active-low reset.
- index  in  IDX_W  pixel palette index.
- pix_valid  in  1  index is valid this cycle.
- wr_en  in  1  palette write strobe.
- wr_addr  in  IDX_W  palette entry to write.
- wr_data  in  3*COLOR_W  {R,G,B} written to wr_addr.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- fade_cmd  in  2  00 none, 01 fade-in, 10 fade-out, 11 snap to MAXL; sampled every cycle.
- fade_frames  in  8  frames per level step; 0 treated as 1.
- red  out  COLOR_W  scaled red.
- green  out  COLOR_W  scaled green.
- blue  out  COLOR_W  scaled blue.
- transparent  out  1  output pixel index equalled TRANSPARENT_IDX.
- out_valid  out  1  pix_valid delayed 2 cycles.
- fade_busy  out  1  FSM not in IDLE.
- fade_level  out  LEVEL_W+1  current brightness level.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - All palette entries are cleared to 0.
  - red, green, blue, transparent and out_valid are cleared to 0.
  - The fade FSM goes to IDLE, with fade_level=MAXL and the frame counter at 0.
- Pipeline, fixed latency 2:
  - Stage 1 registers the palette[index] read, pix_valid and (index==TRANSPARENT_IDX).
  - Stage 2 registers the scaled colour, out_valid and transparent&valid.
  - When pix_valid=0, stage-2 colour outputs hold 0 and transparent=0.
- Scaling:
  - Each channel output = (c * fade_level) / MAXL, truncating.
  - Intermediate width is COLOR_W+LEVEL_W+1.
  - Level MAXL passes c unchanged; level 0 outputs 0.
  - The fade_level used is the value registered at stage 2.
- Write port:
  - A write takes effect at the Clk edge.
  - A read of the same address in the same cycle returns the old entry (read-before-write).
  - Writes are accepted in every FSM state and never stall the pipeline.
- Fade FSM states and transitions:
  - States: IDLE, FADE_IN, FADE_OUT.
  - fade_cmd=01 → FADE_IN; 10 → FADE_OUT. Both clear the frame counter and continue from the current level.
  - fade_cmd=11 → IDLE with level=MAXL.
  - A command equal to the current direction is ignored, and the counter is not cleared.
  - An opposite command mid-fade reverses direction immediately.
  - FADE_IN when level already = MAXL, or FADE_OUT when level already = 0, goes to IDLE on the next cycle.
- Level stepping:
  - In FADE_IN/FADE_OUT, each frame_start increments the frame counter.
  - When the counter reaches max(fade_frames,1)-1, the counter clears and the level steps +1 (FADE_IN) or -1 (FADE_OUT).
  - When the level hits MAXL (FADE_IN) or 0 (FADE_OUT), the FSM goes to IDLE in the same cycle.
  - The level never wraps.
- Simultaneous events:
  - A fade_cmd in the same cycle as frame_start: the command wins and that frame_start is not counted.
  - frame_start in IDLE is ignored.
- Status outputs:
  - fade_busy is 1 exactly while the state is FADE_IN or FADE_OUT.
  - fade_level is the registered level.
- Reset mid-fade aborts the fade, returning the FSM to IDLE with level=MAXL.

Test Plan:
- Reset, then index 5 with pix_valid=1 → after 2 cycles {R,G,B}=0,0,0, out_valid=1, transparent=0; index 0 → transparent=1.
- Write entry 3=12'hF84, then index 3 → RGB=F,8,4 exactly 2 cycles later. Same-cycle write and read of 3 with 12'h123 → old value F84 returned, then 123 on the next read.
- Entry 3=F84, fade_frames=2, fade_cmd=10 pulse, 32 frame_start pulses → level steps 16→0; at level 8 RGB=7,4,2; fade_busy falls the cycle level reaches 0.
- Fade-out at level 10, fade_cmd=01 → immediate FADE_IN, counter cleared, level rises to 16 then IDLE. fade_cmd=11 at level 4 → level=16, IDLE.
- fade_frames=0, FADE_OUT → level drops one per frame_start. frame_start coincident with fade_cmd=01 → that pulse not counted.
- Reset_n=0 for one cycle mid-fade at level 6 with a written palette → outputs 0, fade_level=16, fade_busy=0, and all entries read back 0.
